// File: rtl/seq_lock_pkg.sv
// seq_lock_pkg: shared types and width helpers for the serial code lock.
//   lock_state_t : FSM encoding (LOCKED / UNLOCKED / LOCKOUT)
//   cnt_width()  : width of a counter that must hold 0..n-1 (never below 1)
package seq_lock_pkg;

   typedef enum logic [1:0] {
      LOCKED   = 2'b00,
      UNLOCKED = 2'b01,
      LOCKOUT  = 2'b10
   } lock_state_t;

   localparam int unsigned MIN_CODE_W = 2;
   localparam int unsigned MAX_CODE_W = 32;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_lock_timer.sv
// seq_lock_timer: loadable down-counter that times the lockout period.
//   clock      : rising-edge clock
//   resetphase : asynchronous active-low reset
//   start      : load the counter (one-cycle strobe on lockout entry)
//   busy       : high while the counter is non-zero
// The counter loads LOCKOUT_CYC-1 so that, together with the entry edge,
// the parent holds LOCKOUT for exactly LOCKOUT_CYC cycles.
module seq_lock_timer
   import seq_lock_pkg::*;
#(
   parameter int unsigned LOCKOUT_CYC = 16
) (
   input  logic clock,
   input  logic resetphase,
   input  logic start,
   output logic busy
);

   localparam int unsigned TIMER_W = cnt_width(LOCKOUT_CYC);

   logic [TIMER_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = TIMER_W'(LOCKOUT_CYC - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TIMER_W'(1);
      end
   end

   always_ff @(posedge clock or negedge resetphase) begin
      if (!resetphase) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/seq_lock_gen.sv
// seq_lock_gen: parametrised serial code lock with error counting and lockout.
//   clock      : rising-edge clock
//   resetphase : asynchronous active-low reset
//   seq        : serial code bit (first bit received is the code MSB)
//   seq_valid  : qualifies seq
//   abort      : discard the attempt in progress (no error)
//   det        : one-cycle pulse on a correct code
//   k          : lock state, 1 = unlocked
//   error      : one-cycle pulse on a wrong code
//   lockout    : high while input is ignored after MAX_ERR failures
//   err_cnt    : consecutive-failure count
module seq_lock_gen
   import seq_lock_pkg::*;
#(
   parameter int unsigned       CODE_W      = 4,
   parameter logic [CODE_W-1:0] CODE        = 4'b1011,
   parameter int unsigned       MAX_ERR     = 3,
   parameter int unsigned       LOCKOUT_CYC = 16
) (
   input  logic                             clock,
   input  logic                             resetphase,
   input  logic                             seq,
   input  logic                             seq_valid,
   input  logic                             abort,
   output logic                             det,
   output logic                             k,
   output logic                             error,
   output logic                             lockout,
   output logic [$clog2(MAX_ERR+1)-1:0]     err_cnt
);

   localparam int unsigned ERR_W = $clog2(MAX_ERR + 1);
   localparam int unsigned CNT_W = cnt_width(CODE_W);

   if (CODE_W < MIN_CODE_W || CODE_W > MAX_CODE_W) begin : gen_bad_code_w
      $error("seq_lock_gen: CODE_W must be in 2..32");
   end
   if (MAX_ERR < 1) begin : gen_bad_max_err
      $error("seq_lock_gen: MAX_ERR must be >= 1");
   end
   if (LOCKOUT_CYC < 1) begin : gen_bad_lockout_cyc
      $error("seq_lock_gen: LOCKOUT_CYC must be >= 1");
   end

   lock_state_t          state_q, state_d;
   // Holds the first CODE_W-1 bits; the final bit is combined in directly.
   logic [CODE_W-2:0]    window_q, window_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
   logic                 det_q, det_d;
   logic                 error_q, error_d;
   logic [CODE_W-1:0]    candidate;
   logic                 timer_start;
   logic                 timer_busy;

   assign candidate   = {window_q, seq};
   assign timer_start = (state_q != LOCKOUT) && (state_d == LOCKOUT);

   seq_lock_timer #(
      .LOCKOUT_CYC (LOCKOUT_CYC)
   ) u_timer (
      .clock      (clock),
      .resetphase (resetphase),
      .start      (timer_start),
      .busy       (timer_busy)
   );

   // State register
   always_ff @(posedge clock or negedge resetphase) begin
      if (!resetphase) begin
         state_q   <= LOCKED;
         window_q  <= '0;
         bit_cnt_q <= '0;
         err_cnt_q <= '0;
         det_q     <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         window_q  <= window_d;
         bit_cnt_q <= bit_cnt_d;
         err_cnt_q <= err_cnt_d;
         det_q     <= det_d;
         error_q   <= error_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      window_d  = window_q;
      bit_cnt_d = bit_cnt_q;
      err_cnt_d = err_cnt_q;
      det_d     = 1'b0;
      error_d   = 1'b0;
      unique case (state_q)
         LOCKED, UNLOCKED: begin
            if (abort) begin
               window_d  = '0;
               bit_cnt_d = '0;
            end else if (seq_valid) begin
               if (bit_cnt_q == CNT_W'(CODE_W - 1)) begin
                  window_d  = '0;
                  bit_cnt_d = '0;
                  if (candidate == CODE) begin
                     det_d     = 1'b1;
                     err_cnt_d = '0;
                     state_d   = (state_q == LOCKED) ? UNLOCKED : LOCKED;
                  end else begin
                     error_d   = 1'b1;
                     err_cnt_d = err_cnt_q + ERR_W'(1);
                     if (err_cnt_d == ERR_W'(MAX_ERR)) begin
                        state_d = LOCKOUT;
                     end
                  end
               end else begin
                  window_d  = candidate[CODE_W-2:0];
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         LOCKOUT: begin
            window_d  = '0;
            bit_cnt_d = '0;
            if (!timer_busy) begin
               state_d   = LOCKED;
               err_cnt_d = '0;
            end
         end
         default: begin
            state_d   = LOCKED;
            window_d  = '0;
            bit_cnt_d = '0;
            err_cnt_d = '0;
         end
      endcase
   end

   // Outputs, all decoded from registers
   always_comb begin
      k       = (state_q == UNLOCKED);
      lockout = (state_q == LOCKOUT);
      det     = det_q;
      error   = error_q;
      err_cnt = err_cnt_q;
   end

endmodule

// File: tb/tb_seq_lock_gen.sv
module tb_seq_lock_gen;

   logic       clock;
   logic       resetphase;
   logic       seq;
   logic       seq_valid;
   logic       abort;
   logic       det;
   logic       k;
   logic       error;
   logic       lockout;
   logic [1:0] err_cnt;

   int passed;
   int total;
   int lo_cycles;

   seq_lock_gen dut (
      .clock      (clock),
      .resetphase (resetphase),
      .seq        (seq),
      .seq_valid  (seq_valid),
      .abort      (abort),
      .det        (det),
      .k          (k),
      .error      (error),
      .lockout    (lockout),
      .err_cnt    (err_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic b);
      seq       = b;
      seq_valid = 1'b1;
      tick();
      seq_valid = 1'b0;
   endtask

   task automatic send_code(input logic [3:0] c);
      for (int i = 3; i >= 0; i--) send(c[i]);
   endtask

   task automatic reset_release();
      @(posedge clock);
      #1;
      resetphase = 1'b1;
   endtask

   initial begin
      passed     = 0;
      total      = 0;
      resetphase = 1'b0;
      seq        = 1'b0;
      seq_valid  = 1'b0;
      abort      = 1'b0;

      // Reset
      repeat (5) tick();
      chk("rst_det", det, 0);
      chk("rst_err", error, 0);
      chk("rst_k", k, 0);
      chk("rst_lockout", lockout, 0);
      chk("rst_err_cnt", err_cnt, 0);
      resetphase = 1'b1;

      // Lock toggling
      send(1); send(0); send(1);
      chk("t1_det_early", det, 0);
      send(1);
      chk("t1_det", det, 1);
      chk("t1_k", k, 1);
      chk("t1_err", error, 0);
      tick();
      chk("t1_det_one_cycle", det, 0);
      send_code(4'b1011);
      chk("t2_det", det, 1);
      chk("t2_k", k, 0);
      tick();

      // Single error recovery
      send_code(4'b1111);
      chk("e1_err", error, 1);
      chk("e1_det", det, 0);
      chk("e1_err_cnt", err_cnt, 1);
      tick();
      chk("e1_err_one_cycle", error, 0);
      send_code(4'b1011);
      chk("e2_det", det, 1);
      chk("e2_err_cnt", err_cnt, 0);
      chk("e2_k", k, 1);
      tick();

      // Lockout, entered from UNLOCKED
      send_code(4'b0000);
      chk("lo_err_cnt1", err_cnt, 1);
      chk("lo_k_still", k, 1);
      send_code(4'b0000);
      chk("lo_err_cnt2", err_cnt, 2);
      send_code(4'b0000);
      chk("lo_err3", error, 1);
      chk("lo_rise", lockout, 1);
      chk("lo_k0", k, 0);
      chk("lo_err_cnt3", err_cnt, 3);
      lo_cycles = 1;
      for (int i = 3; i >= 0; i--) begin
         send((4'b1011 >> i) & 1);
         chk("lo_no_det", det, 0);
         if (lockout) lo_cycles++;
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         if (lockout) lo_cycles++;
         else break;
      end
      chk("lo_duration", lo_cycles, 16);
      chk("lo_after_k", k, 0);
      chk("lo_after_err_cnt", err_cnt, 0);
      send_code(4'b1011);
      chk("lo_after_det", det, 1);
      chk("lo_after_k1", k, 1);
      tick();

      // Gaps
      send(1);
      repeat (3) tick();
      send(0); send(1); send(1);
      chk("gap_det", det, 1);
      chk("gap_k", k, 0);
      tick();

      // Abort
      send_code(4'b0101);
      chk("ab_pre_err_cnt", err_cnt, 1);
      send(1); send(0);
      abort     = 1'b1;
      seq       = 1'b1;
      seq_valid = 1'b1;
      tick();
      abort     = 1'b0;
      seq_valid = 1'b0;
      chk("ab_no_err", error, 0);
      chk("ab_err_cnt_kept", err_cnt, 1);
      send(1); send(0); send(1);
      chk("ab_no_early", det | error, 0);
      send(1);
      chk("ab_det", det, 1);
      chk("ab_no_err2", error, 0);
      chk("ab_k", k, 1);
      tick();

      // Async reset during the 2nd bit of an attempt
      send_code(4'b1111);
      chk("ar_pre_err_cnt", err_cnt, 1);
      send(1);
      seq       = 1'b0;
      seq_valid = 1'b1;
      @(negedge clock);
      resetphase = 1'b0;
      #1;
      chk("ar_k", k, 0);
      chk("ar_err_cnt", err_cnt, 0);
      seq_valid = 1'b0;
      reset_release();
      send_code(4'b1011);
      chk("ar_det", det, 1);
      chk("ar_k1", k, 1);
      tick();

      // Async reset during lockout
      send_code(4'b0000);
      send_code(4'b0000);
      send_code(4'b0000);
      chk("arl_lockout", lockout, 1);
      @(negedge clock);
      resetphase = 1'b0;
      #1;
      chk("arl_lockout_clr", lockout, 0);
      chk("arl_err_clr", error, 0);
      chk("arl_err_cnt_clr", err_cnt, 0);
      reset_release();
      send_code(4'b1011);
      chk("arl_det", det, 1);
      chk("arl_k", k, 1);
      chk("arl_no_lockout", lockout, 0);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
